mux_sign_bit_relu: RTL and testbench

//  - Streaming ReLU on IEEE-754 binary32 activations: passes the word if the sign bit is 0; otherwise emits ZERO_VALUE.
//  - Sits after each neuron's MAC/adder output, before the next layer's input buffer.
//  - One registered stage with valid/ready handshake and a 2-entry skid buffer, so in_ready is registered.

---
 rtl/mux_sign_bit_pkg.sv | 13 +
 rtl/mux_sign_bit_skid.sv | 80 ++++++++
 rtl/mux_sign_bit_relu.sv | 68 ++++++
 tb/tb_mux_sign_bit_relu.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sign_bit_pkg.sv
// Shared fp32 constants and types for the sign-bit ReLU datapath.
package mux_sign_bit_pkg;

    localparam int unsigned FP32_WIDTH    = 32;
    localparam int unsigned FP32_SIGN_BIT = 31;
    localparam int unsigned CNT_WIDTH     = 32;

    typedef logic [FP32_WIDTH-1:0] fp32_t;

    localparam fp32_t FP32_POS_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_NEG_ZERO = 32'h8000_0000;

endpackage : mux_sign_bit_pkg

// File: rtl/mux_sign_bit_skid.sv
// Generic 2-entry skid buffer: one output register plus one skid register,
// with a registered in_ready that drops once the skid entry is occupied.
module mux_sign_bit_skid #(
    parameter int unsigned DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [DW-1:0] r_main;
    logic          r_main_valid;
    logic [DW-1:0] r_skid;
    logic          r_skid_valid;
    logic          r_in_ready;

    logic [DW-1:0] w_main_n;
    logic          w_main_valid_n;
    logic [DW-1:0] w_skid_n;
    logic          w_skid_valid_n;
    logic          w_in_ready_n;
    logic          w_accept;
    logic          w_out_free;

    // Next-state: refill the output register from skid first, then from input.
    always_comb begin
        w_main_n       = r_main;
        w_main_valid_n = r_main_valid;
        w_skid_n       = r_skid;
        w_skid_valid_n = r_skid_valid;
        w_accept       = in_valid & r_in_ready;
        w_out_free     = ~r_main_valid | out_ready;

        if (w_out_free) begin
            if (r_skid_valid) begin
                // in_ready is low whenever skid is full, so no accept here
                w_main_n       = r_skid;
                w_main_valid_n = 1'b1;
                w_skid_valid_n = 1'b0;
            end else if (w_accept) begin
                w_main_n       = in_data;
                w_main_valid_n = 1'b1;
            end else begin
                w_main_valid_n = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_n       = in_data;
            w_skid_valid_n = 1'b1;
        end

        w_in_ready_n = ~w_skid_valid_n;
    end

    // State registers; reset discards any held words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main       <= w_main_n;
            r_main_valid <= w_main_valid_n;
            r_skid       <= w_skid_n;
            r_skid_valid <= w_skid_valid_n;
            r_in_ready   <= w_in_ready_n;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main;

endmodule : mux_sign_bit_skid

// File: rtl/mux_sign_bit_relu.sv
// Streaming sign-bit ReLU: negative words (sign bit set) become ZERO_VALUE,
// others pass unchanged; the result and a clamp flag go through a skid buffer.
// Optional macro MUX_SIGN_BIT_RELU_CNT_EN adds a saturating clamp_count port.
module mux_sign_bit_relu
    import mux_sign_bit_pkg::*;
#(
    parameter int unsigned      WIDTH      = FP32_WIDTH,
    parameter logic [WIDTH-1:0] ZERO_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_clamp
`ifdef MUX_SIGN_BIT_RELU_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] clamp_count
`endif
);

    localparam int unsigned DW = WIDTH + 1;

    logic             w_clamp;
    logic [WIDTH-1:0] w_relu;
    logic [DW-1:0]    w_skid_out;

    // Sign-bit mux: decision is purely on the MSB, NaN/inf included.
    always_comb begin
        w_clamp = in_data[WIDTH-1];
        w_relu  = w_clamp ? ZERO_VALUE : in_data;
    end

    mux_sign_bit_skid #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({w_clamp, w_relu}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_skid_out)
    );

    assign out_data  = w_skid_out[WIDTH-1:0];
    assign out_clamp = w_skid_out[WIDTH];

`ifdef MUX_SIGN_BIT_RELU_CNT_EN
    logic [CNT_WIDTH-1:0] r_clamp_count;

    // Count clamped words as they leave; hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clamp_count <= '0;
        end else if (out_valid && out_ready && out_clamp && (r_clamp_count != '1)) begin
            r_clamp_count <= r_clamp_count + CNT_WIDTH'(1);
        end
    end

    assign clamp_count = r_clamp_count;
`endif

endmodule : mux_sign_bit_relu

// File: tb/tb_mux_sign_bit_relu.sv
// Directed self-checking bench for mux_sign_bit_relu.
module tb_mux_sign_bit_relu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_clamp;
`ifdef MUX_SIGN_BIT_RELU_CNT_EN
    logic [31:0] clamp_count;
`endif

    int n_vec;
    int n_err;

    mux_sign_bit_relu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_clamp (out_clamp)
`ifdef MUX_SIGN_BIT_RELU_CNT_EN
        ,
        .clamp_count (clamp_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({out_valid, in_ready, out_clamp} !== 3'b010 || out_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset: valid/ready/clamp=%b data=%h, want 010 data=00000000",
                     {out_valid, in_ready, out_clamp}, out_data);
        end
    endtask

    task automatic test_pass_positive();
        in_valid = 1'b1; in_data = 32'h3E4C_CCCD; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 'x;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h3E4C_CCCD || out_clamp !== 1'b0) begin
            n_err++;
            $display("FAIL pass_pos: v=%b d=%h c=%b, want v=1 d=3e4ccccd c=0",
                     out_valid, out_data, out_clamp);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pass_pos_drain: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_clamp_negative();
        in_valid = 1'b1; in_data = 32'hBE4C_CCCD;
        tick();
        in_valid = 1'b0; in_data = 'x;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h0 || out_clamp !== 1'b1) begin
            n_err++;
            $display("FAIL clamp_neg: v=%b d=%h c=%b, want v=1 d=00000000 c=1",
                     out_valid, out_data, out_clamp);
        end
        tick();
    endtask

    // X on in_data while idle must never show up on out_data.
    task automatic test_idle_x();
        in_valid = 1'b0; in_data = 'x;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_clamp !== 1'b1) begin
            n_err++;
            $display("FAIL idle_x: v=%b d=%h c=%b, want v=0 d=00000000 c=1 (held)",
                     out_valid, out_data, out_clamp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin [6];
        logic [31:0] vexp [6];
        vin  = '{32'h3E4C_CCCD, 32'hBE4C_CCCD, 32'h3E4C_CCCD,
                 32'hBE4C_CCCD, 32'h3E4C_CCCD, 32'hBE4C_CCCD};
        vexp = '{32'h3E4C_CCCD, 32'h0, 32'h3E4C_CCCD,
                 32'h0, 32'h3E4C_CCCD, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== vexp[i] ||
                out_clamp !== vin[i][31]) begin
                n_err++;
                $display("FAIL b2b[%0d]: v=%b rdy=%b d=%h c=%b, want v=1 rdy=1 d=%h c=%b",
                         i, out_valid, in_ready, out_data, out_clamp, vexp[i], vin[i][31]);
            end
        end
        in_valid = 1'b0; in_data = 'x;
        tick();
    endtask

    task automatic test_edge_words();
        logic [31:0] vin [6];
        logic [31:0] vexp [6];
        logic        cexp [6];
        vin  = '{32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000,
                 32'hFFC0_0000, 32'hFF80_0000, 32'h7F80_0000};
        vexp = '{32'h0, 32'h0, 32'h7FC0_0000, 32'h0, 32'h0, 32'h7F80_0000};
        cexp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== vexp[i] || out_clamp !== cexp[i]) begin
                n_err++;
                $display("FAIL edge[%h]: v=%b d=%h c=%b, want v=1 d=%h c=%b",
                         vin[i], out_valid, out_data, out_clamp, vexp[i], cexp[i]);
            end
        end
        in_valid = 1'b0; in_data = 'x;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [3];
        logic [31:0] seen [3];
        int          n_seen;
        int          cyc;
        w = '{32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
        // expected outputs: 1.0 passes, -2.0 clamps, 3.0 passes
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = w[0];
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_data !== w[0]) begin
            n_err++;
            $display("FAIL bp_first: rdy=%b v=%b d=%h, want rdy=1 v=1 d=%h",
                     in_ready, out_valid, out_data, w[0]);
        end
        in_data = w[1];
        tick();
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: in_ready=%b, want 0 after 2 accepted", in_ready);
        end
        in_data = w[2];
        for (int i = 0; i < 3; i++) tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== w[0] || out_clamp !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: rdy=%b v=%b d=%h c=%b, want rdy=0 v=1 d=%h c=0",
                     in_ready, out_valid, out_data, out_clamp, w[0]);
        end
        // Release and collect everything with a bounded wait.
        out_ready = 1'b1;
        n_seen = 1;
        seen[0] = out_data;
        cyc = 0;
        while (n_seen < 3 && cyc < 20) begin
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0; in_data = 'x;
            end else begin
                tick();
            end
            cyc++;
            if (out_valid && n_seen < 3) begin
                seen[n_seen] = out_data;
                n_seen++;
            end
        end
        in_valid = 1'b0; in_data = 'x;
        n_vec++;
        if (n_seen != 3 || seen[0] !== w[0] || seen[1] !== 32'h0 || seen[2] !== w[2]) begin
            n_err++;
            $display("FAIL bp_order: got %0d words %h %h %h, want 3 words %h 00000000 %h",
                     n_seen, seen[0], seen[1], seen[2], w[0], w[2]);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_drain: v=%b rdy=%b, want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h3F80_0000;
        tick();
        in_data = 32'h4000_0000;
        tick();
        in_valid = 1'b0; in_data = 'x;
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_clamp !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: v=%b rdy=%b d=%h c=%b, want v=0 rdy=1 d=00000000 c=0",
                     out_valid, in_ready, out_data, out_clamp);
        end
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_after: v=%b rdy=%b, want v=0 rdy=1 (held words lost)",
                     out_valid, in_ready);
        end
    endtask

`ifdef MUX_SIGN_BIT_RELU_CNT_EN
    task automatic test_counter();
        logic [31:0] vin [10];
        vin = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h8000_0000, 32'h0,
                32'h4040_0000, 32'hFFC0_0000, 32'h7FC0_0000, 32'hC000_0000, 32'h3E4C_CCCD};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = vin[i];
            tick();
        end
        in_valid = 1'b0; in_data = 'x;
        tick();
        tick();
        n_vec++;
        if (clamp_count !== 32'd4) begin
            n_err++;
            $display("FAIL cnt: clamp_count=%0d, want 4", clamp_count);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (clamp_count !== 32'd0) begin
            n_err++;
            $display("FAIL cnt_rst: clamp_count=%0d, want 0", clamp_count);
        end
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_pass_positive();
        test_clamp_negative();
        test_idle_x();
        test_back_to_back();
        test_edge_words();
        test_backpressure();
        test_reset_midstream();
`ifdef MUX_SIGN_BIT_RELU_CNT_EN
        test_counter();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule : tb_mux_sign_bit_relu
